svr_gather: RTL
===============

SVR_GATHER -- requirements
Module: svr_gather

Interface
REQ-001 SHALL have parameter NREG, default 32, number of 32-bit SVR entries (address width 5).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start_valid  input  1  gather request valid.
REQ-005 SHALL have port start_ready  output  1  block can accept request.
REQ-006 SHALL have port start_base  input  5  first SVR register index.
REQ-007 SHALL have port start_vl  input  2  length code: 00=1, 01=4, 10=16, 11=illegal.
REQ-008 SHALL have port ra  output  5  read address to SVR read port.
REQ-009 SHALL have port rd  input  32  combinational SVR read data for ra.
REQ-010 SHALL have port out_valid  output  1  gathered vector valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts vector.
REQ-012 SHALL have port out_data  output  512  lane i in bits [32*i+31:32*i].
REQ-013 SHALL have port out_vl  output  2  length code of the returned vector.
REQ-014 SHALL have port out_err  output  1  request used illegal code 11.

Function
REQ-015 SHALL implement states IDLE, GATHER, DONE.
REQ-016 IDLE: start_ready=1, ra=0; on start_valid, latch base and code, clear lane buffer to 0, cnt=0, go to GATHER.
REQ-017 Lane count N SHALL be 1/4/16 for codes 00/01/10; code 11 SHALL be N=1 with out_err=1.
REQ-018 GATHER: ra = (base+cnt) mod 32 combinationally from registers; each cycle SHALL capture rd into lane cnt and increment cnt.
REQ-019 After capturing lane N-1, SHALL go to DONE the next cycle.
REQ-020 Latency: request accepted at edge T; lanes captured at edges T+1..T+N; out_valid high from cycle after T+N.
REQ-021 DONE: out_valid=1, out_data/out_vl/out_err stable; on out_ready go to IDLE; hold indefinitely otherwise.
REQ-022 Lanes ≥ N SHALL read as 0 in out_data.
REQ-023 Address wrap: base 30, N=4 SHALL read 30, 31, 0, 1.
REQ-024 start_ready SHALL be 0 in GATHER and DONE; start_valid there SHALL be ignored, not queued.
REQ-025 No combinational path from start_valid or out_ready to any output.
REQ-026 SHALL NOT forward SVR writes: each lane is the rd value in its capture cycle.
REQ-027 Minimum spacing of two requests: N+2 cycles if out_ready is held high.

Reset
REQ-028 rst SHALL force IDLE: start_ready=1, out_valid=0, out_err=0, out_vl=0, out_data=0, ra=0, cnt=0.
REQ-029 rst mid-GATHER or mid-DONE SHALL discard the partial or pending vector with no output handshake.
REQ-030 rst SHALL take priority over start_valid and out_ready in the same cycle.

Structure
REQ-031 Package svr_pkg SHALL hold VL code constants, the state enum, and function vl_lanes(code) returning 1/4/16.
REQ-032 No sub-module: a single FSM with cnt, base, and lane buffer registers; lane write uses an indexed part-select.

Verification
REQ-033 rf[5]=0xA5A5A5A5, base=5, code=00 -> out_valid 2 cycles after accept; lane0=0xA5A5A5A5, lanes1..15=0, out_err=0.
REQ-034 rf[k]=k+0x100, base=30, code=01 -> ra sequence 30,31,0,1; lanes = 0x11E, 0x11F, 0x100, 0x101.
REQ-035 base=0, code=10, out_ready=0 for 10 cycles -> out_valid at accept+17; data held stable; start_ready=0 until the cycle after out_ready.
REQ-036 code=11, base=7 -> single lane rf[7]; out_err=1; out_vl=11.
REQ-037 rst at third GATHER cycle of a code=10 request -> next cycle IDLE, out_valid=0; a new request then completes correctly.

Source files
------------

// File: rtl/svr_pkg.sv
// svr_gather shared types: length codes, FSM states, lane-count helper.
package svr_pkg;

  localparam int DW    = 32;
  localparam int LANES = 16;

  localparam logic [1:0] VL_1   = 2'b00;
  localparam logic [1:0] VL_4   = 2'b01;
  localparam logic [1:0] VL_16  = 2'b10;
  localparam logic [1:0] VL_ERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    GATHER,
    DONE
  } state_e;

  // Illegal code falls back to one lane.
  function automatic logic [4:0] vl_lanes(input logic [1:0] code);
    logic [4:0] n;
    unique case (code)
      VL_4:    n = 5'd4;
      VL_16:   n = 5'd16;
      default: n = 5'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/svr_gather.sv
// Gathers 1/4/16 consecutive SVR entries into one 512-bit vector.
// Outputs are decoded from registers only, so no input-to-output path.
module svr_gather
  import svr_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [4:0]   start_base,
  input  logic [1:0]   start_vl,
  output logic [4:0]   ra,
  input  logic [31:0]  rd,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_data,
  output logic [1:0]   out_vl,
  output logic         out_err
);

  state_e         state_q, state_d;
  logic [4:0]     base_q, base_d;
  logic [1:0]     code_q, code_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [511:0]   buf_q, buf_d;
  logic [4:0]     lanes;
  logic [5:0]     sum;
  logic [4:0]     addr;

  assign lanes = vl_lanes(code_q);
  assign sum   = {1'b0, base_q} + {1'b0, cnt_q};
  assign addr  = (sum >= 6'(NREG)) ? 5'(sum - 6'(NREG))
                                   : sum[4:0];

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          state_d = GATHER;
          base_d  = start_base;
          code_d  = start_vl;
          cnt_d   = '0;
          buf_d   = '0;
        end
      end
      GATHER: begin
        // One settle cycle after the last capture before DONE.
        if (cnt_q < lanes) begin
          buf_d[{cnt_q[3:0], 5'd0} +: DW] = rd;
          cnt_d = cnt_q + 5'd1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign ra          = (state_q == GATHER) ? addr : '0;
  assign out_data    = buf_q;
  assign out_vl      = code_q;
  assign out_err     = (code_q == VL_ERR);

endmodule
